// File: rtl/ibex_rf_wb_buffer_if.sv
// Handshake, register-file write and forwarding signals of the write-back buffer.
// Signal names keep the buffer's point of view (_i into the buffer, _o out of it).
interface ibex_rf_wb_buffer_if #(
   parameter int unsigned DataWidth = 32
);
   logic                 ex_valid_i;
   logic                 ex_ready_o;
   logic [4:0]           ex_waddr_i;
   logic [31:0]          ex_wdata_i;
   logic                 lsu_valid_i;
   logic                 lsu_ready_o;
   logic [4:0]           lsu_waddr_i;
   logic [31:0]          lsu_wdata_i;
   logic                 wb_stall_i;
   logic [4:0]           rf_waddr_wb_o;
   logic [DataWidth-1:0] rf_wdata_wb_ecc_o;
   logic                 rf_we_wb_o;
   logic [4:0]           fwd_raddr_a_i;
   logic                 fwd_hit_a_o;
   logic [31:0]          fwd_data_a_o;
   logic [4:0]           fwd_raddr_b_i;
   logic                 fwd_hit_b_o;
   logic [31:0]          fwd_data_b_o;
   logic                 wb_empty_o;

   // Producer / register-file side.
   modport master (
      output ex_valid_i, ex_waddr_i, ex_wdata_i,
      output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
      output wb_stall_i, fwd_raddr_a_i, fwd_raddr_b_i,
      input  ex_ready_o, lsu_ready_o,
      input  rf_waddr_wb_o, rf_wdata_wb_ecc_o, rf_we_wb_o,
      input  fwd_hit_a_o, fwd_data_a_o, fwd_hit_b_o, fwd_data_b_o, wb_empty_o
   );

   // Buffer side.
   modport slave (
      input  ex_valid_i, ex_waddr_i, ex_wdata_i,
      input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
      input  wb_stall_i, fwd_raddr_a_i, fwd_raddr_b_i,
      output ex_ready_o, lsu_ready_o,
      output rf_waddr_wb_o, rf_wdata_wb_ecc_o, rf_we_wb_o,
      output fwd_hit_a_o, fwd_data_a_o, fwd_hit_b_o, fwd_data_b_o, wb_empty_o
   );
endinterface

// File: rtl/ibex_rf_wb_buffer.sv
// In-order write-back buffer in front of the register-file write port: arbitrates EX/LSU
// results, optionally SECDED-encodes them, drains one per cycle and forwards buffered data.
module ibex_rf_wb_buffer #(
   parameter bit          RegFileECC       = 1'b0,
   parameter int unsigned RegFileDataWidth = RegFileECC ? 39 : 32,
   parameter int unsigned Depth            = 2
) (
   input logic                clk_i,
   input logic                rst_ni,
   ibex_rf_wb_buffer_if.slave bus
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [RegFileDataWidth-1:0] ZeroWord =
      RegFileECC ? RegFileDataWidth'(39'h2A00000000) : '0;

   logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]             count_q, count_d;
   logic [4:0]                  addr_q [Depth];
   logic [RegFileDataWidth-1:0] word_q [Depth];

   logic                        full, empty;
   logic                        ex_ready, lsu_ready;
   logic                        lsu_push, ex_push, push, pop;
   logic [4:0]                  push_addr;
   logic [31:0]                 push_data;
   logic [RegFileDataWidth-1:0] push_word;
   logic [4:0]                  head_addr;

   logic [4:0]                  fwd_raddr [2];
   logic                        fwd_hit [2];
   logic [31:0]                 fwd_data [2];
   logic [PtrW-1:0]             fwd_idx;

   function automatic logic [38:0] secded_inv_39_32_enc(logic [31:0] data);
      logic [38:0] w;
      w     = {7'b0, data};
      w[32] = ^(w & 39'h002606BD25);
      w[33] = ^(w & 39'h00DEBA8050);
      w[34] = ^(w & 39'h00413D89AA);
      w[35] = ^(w & 39'h0031234ED1);
      w[36] = ^(w & 39'h00C2C1323B);
      w[37] = ^(w & 39'h002DCC624C);
      w[38] = ^(w & 39'h0098505586);
      return w ^ 39'h2A00000000;
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   // Occupancy is judged on registered state only, so a same-cycle pop never frees a slot.
   assign full      = (count_q == CntW'(Depth));
   assign empty     = (count_q == '0);
   assign lsu_ready = !full;
   assign ex_ready  = !full && !bus.lsu_valid_i;
   assign lsu_push  = bus.lsu_valid_i && lsu_ready;
   assign ex_push   = bus.ex_valid_i && ex_ready;
   assign push      = lsu_push || ex_push;
   assign pop       = !empty && !bus.wb_stall_i;
   assign push_addr = lsu_push ? bus.lsu_waddr_i : bus.ex_waddr_i;
   assign push_data = lsu_push ? bus.lsu_wdata_i : bus.ex_wdata_i;

   if (RegFileECC) begin : gen_ecc
      assign push_word = RegFileDataWidth'(secded_inv_39_32_enc(push_data));
   end else begin : gen_no_ecc
      assign push_word = RegFileDataWidth'(push_data);
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < Depth; i++) begin
            addr_q[i] <= '0;
            word_q[i] <= ZeroWord;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push) begin
            addr_q[wr_ptr_q] <= push_addr;
            word_q[wr_ptr_q] <= push_word;
         end
      end
   end

   assign head_addr             = addr_q[rd_ptr_q];
   assign bus.ex_ready_o        = ex_ready;
   assign bus.lsu_ready_o       = lsu_ready;
   assign bus.rf_waddr_wb_o     = empty ? 5'd0 : head_addr;
   assign bus.rf_wdata_wb_ecc_o = empty ? ZeroWord : word_q[rd_ptr_q];
   // x0 entries still drain, they just never strobe the write enable.
   assign bus.rf_we_wb_o        = pop && (head_addr != 5'd0);
   assign bus.wb_empty_o        = empty;

   assign fwd_raddr[0] = bus.fwd_raddr_a_i;
   assign fwd_raddr[1] = bus.fwd_raddr_b_i;

   // Walk from oldest to youngest so the youngest matching entry wins.
   always_comb begin
      fwd_idx = '0;
      for (int unsigned p = 0; p < 2; p++) begin
         fwd_hit[p]  = 1'b0;
         fwd_data[p] = '0;
         for (int unsigned k = 0; k < Depth; k++) begin
            fwd_idx = PtrW'((32'(rd_ptr_q) + k) % Depth);
            if (k < 32'(count_q) && fwd_raddr[p] != 5'd0 && addr_q[fwd_idx] == fwd_raddr[p]) begin
               fwd_hit[p]  = 1'b1;
               fwd_data[p] = word_q[fwd_idx][31:0];
            end
         end
      end
   end

   assign bus.fwd_hit_a_o  = fwd_hit[0];
   assign bus.fwd_data_a_o = fwd_data[0];
   assign bus.fwd_hit_b_o  = fwd_hit[1];
   assign bus.fwd_data_b_o = fwd_data[1];

   a_legal_params: assert property (@(posedge clk_i)
      (Depth == 2 || Depth == 4) && (RegFileDataWidth == (RegFileECC ? 39 : 32)));
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (push |-> !full) && (count_q <= CntW'(Depth)));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> !empty);
   a_known_outputs: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({bus.ex_ready_o, bus.lsu_ready_o, bus.rf_waddr_wb_o, bus.rf_wdata_wb_ecc_o,
                   bus.rf_we_wb_o, bus.fwd_hit_a_o, bus.fwd_data_a_o, bus.fwd_hit_b_o,
                   bus.fwd_data_b_o, bus.wb_empty_o}));
endmodule
